// File: rtl/hex_price_display.sv
// Avalon-MM peripheral: a 20-bit binary value is converted to six BCD digits by a
// serial double-dabble engine and shown on six active-low seven-segment displays.
module hex_price_display #(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5
);

  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int BW       = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(HALF - 1);
  localparam logic [19:0]   MAX_VALUE = 20'd999999;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t        state_reg, state_next;
  logic [23:0]   bcd_reg, bcd_next, bcd_adj;
  logic [19:0]   bin_reg, bin_next;
  logic [4:0]    cnt_reg, cnt_next;
  logic [23:0]   digits_reg, digits_next;
  logic [19:0]   value_reg;
  logic [2:0]    ctrl_reg;
  logic          ovf_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          phase_reg;
  logic [6:0]    hex_reg [6];
  logic [5:0]    lead_zero;

  logic        wr_value, wr_ctrl, wr_status, over, busy;
  logic [19:0] load_val;
  logic        unused_bits;

  assign wr_value  = chipselect && write && (address == 2'd0);
  assign wr_ctrl   = chipselect && write && (address == 2'd1);
  assign wr_status = chipselect && write && (address == 2'd2);
  assign over      = writedata[19:0] > MAX_VALUE;
  assign load_val  = over ? MAX_VALUE : writedata[19:0];
  assign busy      = (state_reg != IDLE);
  assign unused_bits = ^writedata[31:20];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Add-3 correction applied to every nibble before each shift.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      bcd_reg    <= '0;
      bin_reg    <= '0;
      cnt_reg    <= '0;
      digits_reg <= '0;
    end else begin
      state_reg  <= state_next;
      bcd_reg    <= bcd_next;
      bin_reg    <= bin_next;
      cnt_reg    <= cnt_next;
      digits_reg <= digits_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bcd_next    = bcd_reg;
    bin_next    = bin_reg;
    cnt_next    = cnt_reg;
    digits_next = digits_reg;
    case (state_reg)
      IDLE: ;
      SHIFT: begin
        {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) state_next = LATCH;
      end
      LATCH: begin
        digits_next = bcd_reg;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A new value always wins, including over a pending latch of the old one.
    if (wr_value) begin
      bin_next    = load_val;
      bcd_next    = '0;
      cnt_next    = 5'd20;
      digits_next = digits_reg;
      state_next  = SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= '0;
      ctrl_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      if (wr_value) value_reg <= load_val;
      if (wr_ctrl)  ctrl_reg  <= writedata[2:0];
      if (wr_value && over)                ovf_reg <= 1'b1;
      else if (wr_status && writedata[1])  ovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (wr_ctrl) begin
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
    end else if (blink_cnt_reg == BLINK_MAX) begin
      blink_cnt_reg <= '0;
      phase_reg     <= ~phase_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      case (address)
        2'd0:    readdata <= {12'd0, value_reg};
        2'd1:    readdata <= {29'd0, ctrl_reg};
        2'd2:    readdata <= {30'd0, ovf_reg, busy};
        default: readdata <= '0;
      endcase
    end
  end

  // hex0 is never suppressed so a zero value still shows "0".
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
      logic blank;
      assign lead_zero[gi] = (digits_reg[23:4*gi] == '0);
      if (gi == 0) begin : g_lsd
        assign blank = !ctrl_reg[0] || (ctrl_reg[1] && phase_reg);
      end else begin : g_msd
        assign blank = !ctrl_reg[0] || (ctrl_reg[1] && phase_reg) ||
                       (ctrl_reg[2] && lead_zero[gi]);
      end
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hex_reg[gi] <= 7'h7F;
        else          hex_reg[gi] <= blank ? 7'h7F : seg7(digits_reg[4*gi +: 4]);
      end
    end
  endgenerate

  assign hex0 = hex_reg[0];
  assign hex1 = hex_reg[1];
  assign hex2 = hex_reg[2];
  assign hex3 = hex_reg[3];
  assign hex4 = hex_reg[4];
  assign hex5 = hex_reg[5];

endmodule

// File: tb/tb_hex_price_display.sv
// Self-checking bench for hex_price_display: table vectors, exact-latency
// conversion sequences, randomized values against a decimal model, blink and reset.
module tb_hex_price_display;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] readdata;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [41:0] hex_bus;

  int checks = 0;
  int errors = 0;

  assign hex_bus = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Half blink period of 4 cycles.
  hex_price_display #(.CLK_HZ(800), .BLINK_HZ(100)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(cs), .write(wr), .read(rd),
    .address(addr), .writedata(wdata), .readdata(readdata),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [41:0] exp_hex;
    logic [31:0] exp_value;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; default: return 7'h10;
    endcase
  endfunction

  function automatic int unsigned sat(input logic [31:0] w);
    int unsigned v = w[19:0];
    return (v > 999999) ? 999999 : v;
  endfunction

  // Expected {hex5..hex0} from the decimal value and the CTRL bits.
  function automatic logic [41:0] model_hex(input int unsigned v, input logic [2:0] c, input bit phase);
    logic [41:0] r = '0;
    int unsigned p = 1;
    for (int i = 0; i < 6; i++) begin
      bit blank = !c[0] || (c[1] && phase) || (c[2] && i > 0 && v < p);
      r[7*i +: 7] = blank ? 7'h7F : seg_of(int'((v / p) % 10));
      p = p * 10;
    end
    return r;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk); cs = 1; wr = 1; rd = 0; addr = a; wdata = d;
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk); cs = 1; rd = 1; wr = 0; addr = a;
    @(negedge clk); d = readdata; cs = 0; rd = 0;
  endtask

  // Writes VALUE, polls STATUS every cycle and checks the exact display latency.
  task automatic do_convert(input logic [31:0] v, input logic [41:0] old_exp,
                            input logic [41:0] new_exp, input bit use_forbid,
                            input logic [41:0] forbid, input string name);
    int busy_cnt = 0;
    bit seen_forbid = 0;
    @(negedge clk); cs = 1; wr = 1; rd = 0; addr = 2'd0; wdata = v;
    @(negedge clk); wr = 0; rd = 1; addr = 2'd2;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (readdata[0]) busy_cnt++;
      if (hex_bus == forbid) seen_forbid = 1;
      if (k == 21) check({name, "_before_latch"}, hex_bus, old_exp);
      if (k == 22) check(name, hex_bus, new_exp);
    end
    rd = 0; cs = 0;
    check({name, "_busy_cycles"}, 42'(busy_cnt), 42'd21);
    if (use_forbid) check({name, "_old_never_shown"}, 42'(seen_forbid), 42'd0);
  endtask

  initial begin
    logic [31:0] rv;
    int unsigned prev_val;
    logic [2:0] c;
    logic [31:0] w;

    vecs[0] = '{32'd42,         3'd5, {7'h7F,7'h7F,7'h7F,7'h7F,7'h19,7'h24}, 32'd42, 32'd0};
    vecs[1] = '{32'd0,          3'd5, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 32'd0, 32'd0};
    vecs[2] = '{32'd1000000,    3'd1, {6{7'h10}},                            32'd999999, 32'd2};
    vecs[3] = '{32'd999999,     3'd5, {6{7'h10}},                            32'd999999, 32'd0};
    vecs[4] = '{32'd100000,     3'd5, {7'h79,7'h40,7'h40,7'h40,7'h40,7'h40}, 32'd100000, 32'd0};
    vecs[5] = '{32'd1005,       3'd5, {7'h7F,7'h7F,7'h79,7'h40,7'h40,7'h12}, 32'd1005, 32'd0};
    vecs[6] = '{32'd7,          3'd0, {6{7'h7F}},                            32'd7, 32'd0};
    vecs[7] = '{32'hFFF0_0003,  3'd5, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h30}, 32'd3, 32'd0};
    vecs[8] = '{32'd1048575,    3'd1, {6{7'h10}},                            32'd999999, 32'd2};
    vecs[9] = '{32'd86,         3'd1, {7'h40,7'h40,7'h40,7'h40,7'h00,7'h02}, 32'd86, 32'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hex_blank", hex_bus, {6{7'h7F}});
    check("reset_readdata", 42'(readdata), 42'd0);
    reset_n = 1;
    bus_read(2'd0, rv); check("reset_value", 42'(rv), 42'd0);
    bus_read(2'd1, rv); check("reset_ctrl", 42'(rv), 42'd0);
    bus_read(2'd2, rv); check("reset_status", 42'(rv), 42'd0);

    // Basic conversion with exact latency
    bus_write(2'd1, 32'd1);
    repeat (2) @(negedge clk);
    do_convert(32'd123456, {6{7'h40}}, {7'h79,7'h24,7'h30,7'h19,7'h12,7'h02}, 0, '0, "conv_123456");
    bus_read(2'd0, rv); check("value_123456", 42'(rv), 42'd123456);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      bus_write(2'd1, {29'd0, vecs[i].ctrl});
      bus_write(2'd0, vecs[i].wdata);
      repeat (25) @(negedge clk);
      check($sformatf("vec%0d_hex", i), hex_bus, vecs[i].exp_hex);
      bus_read(2'd0, rv); check($sformatf("vec%0d_value", i), 42'(rv), 42'(vecs[i].exp_value));
      bus_read(2'd2, rv); check($sformatf("vec%0d_status", i), 42'(rv), 42'(vecs[i].exp_status));
      bus_write(2'd2, 32'd2);
      bus_read(2'd2, rv); check($sformatf("vec%0d_status_clr", i), 42'(rv), 42'd0);
    end

    // Restart: latest write wins, first value never displayed
    bus_write(2'd0, 32'd111111);
    repeat (8) @(negedge clk);
    do_convert(32'd222222, model_hex(86, 3'd1, 0), {6{7'h24}}, 1, {6{7'h79}}, "restart_222222");

    // Bus corner cases
    @(negedge clk); cs = 1; wr = 1; rd = 1; addr = 2'd0; wdata = 32'd5;
    @(negedge clk); cs = 0; wr = 0; rd = 0;
    check("rw_same_addr_prewrite", 42'(readdata), 42'd222222);
    repeat (3) @(negedge clk);
    check("readdata_holds", 42'(readdata), 42'd222222);
    repeat (25) @(negedge clk);
    bus_read(2'd0, rv); check("value_after_rw", 42'(rv), 42'd5);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rv); check("addr3_reads_zero", 42'(rv), 42'd0);
    bus_read(2'd1, rv); check("ctrl_after_addr3_write", 42'(rv), 42'd1);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rv); check("ctrl_upper_bits_zero", 42'(rv), 42'd7);
    prev_val = 5;

    // Randomized values against the decimal model
    for (int i = 0; i < 30; i++) begin
      c = 3'($urandom_range(0, 7)) & 3'b101;
      case ($urandom_range(0, 3))
        0:       w = $urandom;
        1:       w = 32'($urandom_range(0, 999));
        2:       w = 32'($urandom_range(999990, 1000010));
        default: w = 32'($urandom_range(0, 1048575));
      endcase
      bus_write(2'd1, {29'd0, c});
      repeat (2) @(negedge clk);
      do_convert(w, model_hex(prev_val, c, 0), model_hex(sat(w), c, 0), 0, '0,
                 $sformatf("rand%0d_v%0d_c%0d", i, w[19:0], c));
      bus_read(2'd2, rv);
      check($sformatf("rand%0d_ovf", i), 42'(rv), (w[19:0] > 20'd999999) ? 42'd2 : 42'd0);
      bus_write(2'd2, 32'd2);
      prev_val = sat(w);
    end

    // Blink: 4 cycles shown, 4 cycles blank, starting from the CTRL write
    bus_write(2'd1, 32'd3);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), hex_bus, model_hex(prev_val, 3'd3, ((k - 1) / 4) % 2));
    end

    // Reset in the middle of a conversion
    bus_write(2'd0, 32'd654321);
    repeat (5) @(negedge clk);
    reset_n = 0;
    #1;
    check("midreset_hex_blank", hex_bus, {6{7'h7F}});
    check("midreset_readdata", 42'(readdata), 42'd0);
    @(negedge clk); reset_n = 1;
    bus_read(2'd2, rv); check("midreset_status", 42'(rv), 42'd0);
    bus_read(2'd0, rv); check("midreset_value", 42'(rv), 42'd0);
    bus_write(2'd1, 32'd1);
    repeat (25) @(negedge clk);
    check("midreset_digits_zero", hex_bus, {6{7'h40}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
